// File: rtl/light_sequencer.sv
// Traffic-light sequencer: main/side/walk phases, each timed by a seconds counter
// loaded from the downstream-facing parameter store after a short settle window.
module light_sequencer #(
   parameter int VALUE_W     = 4,
   parameter int LOAD_CYCLES = 2
) (
   input  logic               clock,
   input  logic               reset_sync,
   input  logic               one_hz_enable,
   input  logic               sensor_sync,
   input  logic               walk_request_sync,
   input  logic [VALUE_W-1:0] value,
   output logic [1:0]         interval,
   output logic [2:0]         main_lights,
   output logic [2:0]         side_lights,
   output logic               walk_lamp,
   output logic [2:0]         state_dbg
);

   typedef enum logic [2:0] {
      MG     = 3'd0,
      MG_EXT = 3'd1,
      MY     = 3'd2,
      SG     = 3'd3,
      SG_EXT = 3'd4,
      SY     = 3'd5,
      WALK   = 3'd6,
      UNUSED = 3'd7
   } state_t;

   localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
   localparam logic [LC_W-1:0] LOAD_LAST = LC_W'(LOAD_CYCLES - 1);

   state_t             state_q, state_d;
   logic               load_q, load_d;
   logic [LC_W-1:0]    load_cnt_q, load_cnt_d;
   logic [VALUE_W-1:0] count_q, count_d;
   logic               walk_pending_q, walk_pending_d;
   logic [1:0]         interval_q, interval_d;
   logic [2:0]         main_q, main_d;
   logic [2:0]         side_q, side_d;
   logic               walk_lamp_q, walk_lamp_d;

   always_comb begin
      state_d        = state_q;
      load_d         = load_q;
      load_cnt_d     = load_cnt_q;
      count_d        = count_q;
      walk_pending_d = walk_pending_q | walk_request_sync;

      if (state_q == UNUSED) begin
         state_d    = MG;
         load_d     = 1'b1;
         load_cnt_d = '0;
      end else if (load_q) begin
         // The store needs one clock to present the new interval's value.
         if (load_cnt_q == LOAD_LAST) begin
            load_d  = 1'b0;
            count_d = (value == '0) ? VALUE_W'(1) : value;
         end else begin
            load_cnt_d = load_cnt_q + 1'b1;
         end
      end else if (one_hz_enable) begin
         if (count_q > VALUE_W'(1)) begin
            count_d = count_q - 1'b1;
         end else begin
            load_d     = 1'b1;
            load_cnt_d = '0;
            case (state_q)
               MG:      state_d = sensor_sync ? MG_EXT : MY;
               MG_EXT:  state_d = MY;
               MY:      state_d = SG;
               SG:      state_d = sensor_sync ? SG_EXT : SY;
               SG_EXT:  state_d = SY;
               SY:      state_d = walk_pending_q ? WALK : MG;
               default: state_d = MG;
            endcase
         end
      end

      if ((state_d == WALK) && (state_q != WALK)) begin
         walk_pending_d = 1'b0;
      end
   end

   // Outputs are decoded from the next state so they register on the state edge.
   always_comb begin
      interval_d  = 2'b00;
      main_d      = 3'b100;
      side_d      = 3'b100;
      walk_lamp_d = 1'b0;
      case (state_d)
         MG_EXT: begin
            interval_d = 2'b01;
            main_d     = 3'b001;
         end
         MY: begin
            interval_d = 2'b10;
            main_d     = 3'b010;
         end
         SG: begin
            side_d = 3'b001;
         end
         SG_EXT: begin
            interval_d = 2'b01;
            side_d     = 3'b001;
         end
         SY: begin
            interval_d = 2'b10;
            side_d     = 3'b010;
         end
         WALK: begin
            interval_d  = 2'b01;
            walk_lamp_d = 1'b1;
         end
         default: begin
            main_d = 3'b001;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset_sync) begin
         state_q        <= MG;
         load_q         <= 1'b1;
         load_cnt_q     <= '0;
         count_q        <= '0;
         walk_pending_q <= 1'b0;
         interval_q     <= 2'b00;
         main_q         <= 3'b001;
         side_q         <= 3'b100;
         walk_lamp_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         load_q         <= load_d;
         load_cnt_q     <= load_cnt_d;
         count_q        <= count_d;
         walk_pending_q <= walk_pending_d;
         interval_q     <= interval_d;
         main_q         <= main_d;
         side_q         <= side_d;
         walk_lamp_q    <= walk_lamp_d;
      end
   end

   assign interval    = interval_q;
   assign main_lights = main_q;
   assign side_lights = side_q;
   assign walk_lamp   = walk_lamp_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: a registered parameter-store model feeds value, and a
// scoreboard of expected state visits is checked on every state change.
module tb_light_sequencer;

   localparam int VALUE_W     = 4;
   localparam int LOAD_CYCLES = 2;

   logic               clock;
   logic               reset_sync;
   logic               one_hz_enable;
   logic               sensor_sync;
   logic               walk_request_sync;
   logic [VALUE_W-1:0] value;
   logic [1:0]         interval;
   logic [2:0]         main_lights;
   logic [2:0]         side_lights;
   logic               walk_lamp;
   logic [2:0]         state_dbg;

   light_sequencer #(.VALUE_W(VALUE_W), .LOAD_CYCLES(LOAD_CYCLES)) dut (
      .clock             (clock),
      .reset_sync        (reset_sync),
      .one_hz_enable     (one_hz_enable),
      .sensor_sync       (sensor_sync),
      .walk_request_sync (walk_request_sync),
      .value             (value),
      .interval          (interval),
      .main_lights       (main_lights),
      .side_lights       (side_lights),
      .walk_lamp         (walk_lamp),
      .state_dbg         (state_dbg)
   );

   typedef struct {
      int sc;
      int st;
      int pulses;
      int clocks;
      bit term;
   } visit_t;

   visit_t vt[$];
   visit_t sb[$];
   visit_t e_mon;

   int n_checks = 0;
   int n_fail   = 0;
   int en_period = 4;
   int en_div    = 0;
   logic [VALUE_W-1:0] base_val = 4'd6;
   logic [VALUE_W-1:0] ext_val  = 4'd3;
   logic [VALUE_W-1:0] yel_val  = 4'd2;

   logic en_e;
   logic rst_e;
   int   mon_state;
   int   mon_clks;
   int   mon_pulses;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      one_hz_enable = 1'b0;
      forever begin
         @(negedge clock);
         if (en_div >= en_period - 1) begin
            one_hz_enable = 1'b1;
            en_div = 0;
         end else begin
            one_hz_enable = 1'b0;
            en_div++;
         end
      end
   end

   // Parameter store: one-cycle registered lookup of the selected interval.
   always @(posedge clock) begin
      case (interval)
         2'b00:   value <= base_val;
         2'b01:   value <= ext_val;
         2'b10:   value <= yel_val;
         default: value <= '0;
      endcase
   end

   function automatic logic [31:0] exp_out(input int st);
      logic [8:0] r;
      case (st)
         0:       r = {2'b00, 3'b001, 3'b100, 1'b0};
         1:       r = {2'b01, 3'b001, 3'b100, 1'b0};
         2:       r = {2'b10, 3'b010, 3'b100, 1'b0};
         3:       r = {2'b00, 3'b100, 3'b001, 1'b0};
         4:       r = {2'b01, 3'b100, 3'b001, 1'b0};
         5:       r = {2'b10, 3'b100, 3'b010, 1'b0};
         6:       r = {2'b01, 3'b100, 3'b100, 1'b1};
         default: r = '1;
      endcase
      return {23'd0, r};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic add_visit(input int sc, input int st, input int pulses,
                            input int clocks, input bit term);
      visit_t v;
      v.sc = sc; v.st = st; v.pulses = pulses; v.clocks = clocks; v.term = term;
      vt.push_back(v);
   endtask

   task automatic load_scenario(input int sc);
      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].sc == sc) sb.push_back(vt[i]);
      end
   endtask

   task automatic applyStimulus(input logic sensor, input int period,
                                input logic [VALUE_W-1:0] b, input logic [VALUE_W-1:0] x,
                                input logic [VALUE_W-1:0] y);
      @(negedge clock);
      reset_sync        = 1'b1;
      sensor_sync       = sensor;
      walk_request_sync = 1'b0;
      en_period         = period;
      base_val          = b;
      ext_val           = x;
      yel_val           = y;
      sb.delete();
      repeat (2) @(negedge clock);
      checkOutput("reset_state", {29'd0, state_dbg}, 32'd0);
      checkOutput("reset_outputs", {23'd0, interval, main_lights, side_lights, walk_lamp},
                  exp_out(0));
      reset_sync = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      checkOutput(name, sb.size(), 32'd0);
      sb.delete();
   endtask

   task automatic pulse_walk();
      @(negedge clock);
      walk_request_sync = 1'b1;
      @(negedge clock);
      walk_request_sync = 1'b0;
   endtask

   // Tracks each state visit; pulses during the load window are not counted.
   always @(posedge clock) begin
      en_e  = one_hz_enable;
      rst_e = reset_sync;
      #1;
      if (rst_e) begin
         mon_state  = int'(state_dbg);
         mon_clks   = 0;
         mon_pulses = 0;
      end else begin
         mon_clks++;
         if (en_e && mon_clks > LOAD_CYCLES) mon_pulses++;
         checkOutput("lamp_invariant",
                     {31'd0, (main_lights != 3'b100) && (side_lights != 3'b100)}, 32'd0);
         if (int'(state_dbg) != mon_state) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_transition", {29'd0, state_dbg}, mon_state);
            end else begin
               e_mon = sb.pop_front();
               checkOutput($sformatf("exit_state_%0d", e_mon.st), mon_state, e_mon.st);
               checkOutput($sformatf("pulses_in_state_%0d", e_mon.st), mon_pulses, e_mon.pulses);
               if (e_mon.clocks != 0)
                  checkOutput($sformatf("clocks_in_state_%0d", e_mon.st), mon_clks, e_mon.clocks);
               if (sb.size() == 0) begin
                  checkOutput("entry_unexpected", {29'd0, state_dbg}, mon_state);
               end else begin
                  checkOutput("entry_state", {29'd0, state_dbg}, sb[0].st);
                  checkOutput($sformatf("entry_outputs_%0d", sb[0].st),
                              {23'd0, interval, main_lights, side_lights, walk_lamp},
                              exp_out(sb[0].st));
                  if (sb[0].term) void'(sb.pop_front());
               end
            end
            mon_state  = int'(state_dbg);
            mon_clks   = 0;
            mon_pulses = 0;
         end
      end
   end

   initial begin
      reset_sync        = 1'b1;
      sensor_sync       = 1'b0;
      walk_request_sync = 1'b0;

      // Basic cycle, no sensor, no walk.
      add_visit(0, 0, 6, 0, 0); add_visit(0, 2, 2, 0, 0); add_visit(0, 3, 6, 0, 0);
      add_visit(0, 5, 2, 0, 0); add_visit(0, 0, 0, 0, 1);
      // Sensor held: both greens extend.
      add_visit(1, 0, 6, 0, 0); add_visit(1, 1, 3, 0, 0); add_visit(1, 2, 2, 0, 0);
      add_visit(1, 3, 6, 0, 0); add_visit(1, 4, 3, 0, 0); add_visit(1, 5, 2, 0, 0);
      add_visit(1, 0, 0, 0, 1);
      // Walk request in MG: one WALK, then the next cycle skips it.
      add_visit(2, 0, 6, 0, 0); add_visit(2, 2, 2, 0, 0); add_visit(2, 3, 6, 0, 0);
      add_visit(2, 5, 2, 0, 0); add_visit(2, 6, 3, 0, 0); add_visit(2, 0, 6, 0, 0);
      add_visit(2, 2, 2, 0, 0); add_visit(2, 3, 6, 0, 0); add_visit(2, 5, 2, 0, 0);
      add_visit(2, 0, 0, 0, 1);
      // Enable every clock: exact clock counts.
      add_visit(3, 0, 6, 8, 0); add_visit(3, 2, 2, 4, 0); add_visit(3, 3, 6, 8, 0);
      add_visit(3, 5, 2, 4, 0); add_visit(3, 0, 0, 0, 1);
      // Base reprogrammed 6 -> 9 mid-MG.
      add_visit(4, 0, 6, 0, 0); add_visit(4, 2, 2, 0, 0); add_visit(4, 3, 9, 0, 0);
      add_visit(4, 5, 2, 0, 0); add_visit(4, 0, 0, 0, 1);
      // Walk pending, then reset mid-SY.
      add_visit(5, 0, 6, 0, 0); add_visit(5, 2, 2, 0, 0); add_visit(5, 3, 6, 0, 0);
      add_visit(5, 5, 0, 0, 1);
      add_visit(6, 0, 6, 0, 0); add_visit(6, 2, 2, 0, 0); add_visit(6, 3, 6, 0, 0);
      add_visit(6, 5, 2, 0, 0); add_visit(6, 0, 0, 0, 1);

      for (int sc = 0; sc < 5; sc++) begin
         case (sc)
            1:       applyStimulus(1'b1, 4, 4'd6, 4'd3, 4'd2);
            3:       applyStimulus(1'b0, 1, 4'd6, 4'd3, 4'd2);
            default: applyStimulus(1'b0, 4, 4'd6, 4'd3, 4'd2);
         endcase
         load_scenario(sc);
         if (sc == 2) begin
            repeat (5) @(negedge clock);
            pulse_walk();
         end
         if (sc == 4) begin
            repeat (12) @(negedge clock);
            base_val = 4'd9;
         end
         drain($sformatf("scenario_%0d_timeout", sc));
      end

      applyStimulus(1'b0, 4, 4'd6, 4'd3, 4'd2);
      load_scenario(5);
      repeat (5) @(negedge clock);
      pulse_walk();
      drain("scenario_5_timeout");
      repeat (2) @(negedge clock);
      reset_sync = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("midsy_reset_state", {29'd0, state_dbg}, 32'd0);
      checkOutput("midsy_reset_outputs", {23'd0, interval, main_lights, side_lights, walk_lamp},
                  exp_out(0));
      @(negedge clock);
      reset_sync = 1'b0;
      load_scenario(6);
      drain("scenario_6_timeout");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
